// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer.
//   jk_op_t  : command opcode, bit 1 drives J and bit 0 drives K
//   state_t  : sequencer FSM state
//   jk_cmd_t : queued command record at the default count width
package jk_pkg;

  localparam int JK_CNT_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_op_t;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  typedef struct packed {
    jk_op_t              op;
    logic [JK_CNT_W-1:0] len;
  } jk_cmd_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO. The head entry is visible on rdata whenever
// the FIFO is non-empty; a write never appears on rdata in the same cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wdata     : write strobe and data (ignored when full)
//   pop, rdata      : read strobe (ignored when empty) and head data
//   full, empty     : occupancy flags
module jk_cmd_fifo
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 + JK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // The extra top pointer bit flips on every wrap so that equal indices
  // can be told apart as either full or empty.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding the J/K inputs of a downstream JK flop.
// Commands are queued through a valid/ready handshake and each is played
// onto J/K for max(len,1) cycles. A model of the flop's Q is kept and any
// divergence from the fed-back Q sets a sticky mismatch flag.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid, cmd_ready  : command handshake
//   cmd_op, cmd_len       : opcode {J,K} and drive-cycle count
//   J, K                  : registered drive to the flop
//   busy                  : a command is being driven
//   q_fb                  : Q returned by the flop
//   q_model, mismatch     : predicted Q and sticky divergence flag
//
// state | meaning
// IDLE  | nothing driven, J=K=0; pops the head as soon as one is queued
// RUN   | driving a command; remaining counts down to its last cycle
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = JK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  output logic             busy,
  input  logic             q_fb,
  output logic             q_model,
  output logic             mismatch
);

  localparam int CMD_W = 2 + CNT_W;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             known;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last_cycle;
  logic [CMD_W-1:0] head;
  logic [1:0]       head_jk;
  logic [CNT_W-1:0] head_len;
  logic [CNT_W-1:0] head_cnt;

  assign cmd_ready  = !full && !rst;
  assign push       = cmd_valid && cmd_ready;
  assign head_jk    = head[CMD_W-1 -: 2];
  assign head_len   = head[CNT_W-1:0];
  assign head_cnt   = (head_len == '0) ? ONE : head_len;
  assign last_cycle = (state == RUN) && (remaining == ONE);
  // Popping on the last RUN cycle chains commands without an idle gap.
  assign pop        = !rst && !empty && ((state == IDLE) || last_cycle);
  assign busy       = (state == RUN);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_op, cmd_len}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      J         <= 1'b0;
      K         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= RUN;
            remaining <= head_cnt;
            J         <= head_jk[1];
            K         <= head_jk[0];
          end else begin
            J <= 1'b0;
            K <= 1'b0;
          end
        end
        RUN: begin
          if (last_cycle) begin
            if (!empty) begin
              remaining <= head_cnt;
              J         <= head_jk[1];
              K         <= head_jk[0];
            end else begin
              state     <= IDLE;
              remaining <= '0;
              J         <= 1'b0;
              K         <= 1'b0;
            end
          end else begin
            remaining <= remaining - ONE;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          J         <= 1'b0;
          K         <= 1'b0;
        end
      endcase
    end
  end

  // The flop has no reset, so the model only becomes trustworthy once a
  // SET or RESET has been driven; until then comparisons are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_model  <= 1'b0;
      known    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (known && (q_fb != q_model)) mismatch <= 1'b1;
      if (J != K) known <= 1'b1;
      case ({J, K})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             J, K, busy, q_model, mismatch;
  logic             q_fb = 1'b0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .q_fb      (q_fb),
    .q_model   (q_model),
    .mismatch  (mismatch)
  );

  // Reference model: a queue of accepted commands and the command being
  // played, with how many drive cycles it still has to show.
  typedef struct {
    logic [1:0] op;
    int         len;
  } cmd_s;

  cmd_s       mq[$];
  int         m_left = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_qm = 1'b0, m_known = 1'b0, m_mm = 1'b0;
  bit         cur_rst = 1'b1;
  logic       flop_q;
  bit         fb_force = 1'b0;
  logic       fb_val = 1'b0;
  int         n_pass = 0, n_total = 0;
  int         n_acc = 0;

  function automatic logic [5:0] exp_vec();
    logic dj, dk, rdy;
    dj  = (m_left > 0) ? m_op[1] : 1'b0;
    dk  = (m_left > 0) ? m_op[0] : 1'b0;
    rdy = !cur_rst && (mq.size() < DEPTH);
    return {dj, dk, (m_left > 0), rdy, m_qm, m_mm};
  endfunction

  // One clock cycle: apply inputs, advance the model across the edge,
  // return just after the following falling edge.
  task automatic cycle(input bit v, input logic [1:0] op, input int len, input bit r);
    bit   acc;
    logic mj, mk, fb;
    cmd_s c;
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
    q_fb      = fb_force ? fb_val : flop_q;
    acc = v && !r && (mq.size() < DEPTH);
    mj  = (m_left > 0) ? m_op[1] : 1'b0;
    mk  = (m_left > 0) ? m_op[0] : 1'b0;
    fb  = q_fb;
    // downstream flop, no reset, driven by the DUT's actual J/K
    case ({J, K})
      2'b01:   flop_q = 1'b0;
      2'b10:   flop_q = 1'b1;
      2'b11:   flop_q = ~flop_q;
      default: ;
    endcase
    if (r) begin
      mq.delete();
      m_left = 0; m_op = 2'b00;
      m_qm = 1'b0; m_known = 1'b0; m_mm = 1'b0;
    end else begin
      if (m_known && (fb !== m_qm)) m_mm = 1'b1;
      if (mj != mk) m_known = 1'b1;
      if (mj && mk) m_qm = ~m_qm;
      else if (mj) m_qm = 1'b1;
      else if (mk) m_qm = 1'b0;
      if (m_left > 0) m_left--;
      if (m_left == 0 && mq.size() > 0) begin
        c = mq.pop_front();
        m_op = c.op;
        m_left = (c.len == 0) ? 1 : c.len;
      end
      if (acc) begin
        c.op = op; c.len = len;
        mq.push_back(c);
        n_acc++;
      end
    end
    cur_rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(0, HOLD, 0, 1);
    cycle(0, HOLD, 0, 1);
    n_total++;
    if ({J, K, busy, q_model, mismatch, dut.known} !== 6'b0)
      $display("FAIL reset_vals: got %b want 000000", {J, K, busy, q_model, mismatch, dut.known});
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
    else n_pass++;
    cycle(0, HOLD, 0, 0);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready_release: got %b want 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_set();
    cycle(0, HOLD, 0, 1);
    cycle(1, SET, 3, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, HOLD, 0, 0);
      n_total++;
      if ({J, K, busy, cmd_ready, q_model, mismatch} !== exp_vec())
        $display("FAIL set c%0d: got %b want %b", i, {J, K, busy, cmd_ready, q_model, mismatch}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({q_model, dut.known, mismatch} !== 3'b110)
      $display("FAIL set_final: got %b want 110", {q_model, dut.known, mismatch});
    else n_pass++;
  endtask

  task automatic test_queue_four();
    cycle(0, HOLD, 0, 1);
    cycle(1, HOLD, 8, 0);
    cycle(1, RESET, 1, 0);
    cycle(1, TOGGLE, 3, 0);
    cycle(1, HOLD, 2, 0);
    cycle(1, SET, 0, 0);
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL queue_full_ready: got %b want 0", cmd_ready);
    else n_pass++;
    cycle(1, SET, 5, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, HOLD, 0, 0);
      n_total++;
      if ({J, K, busy, cmd_ready, q_model, mismatch} !== exp_vec())
        $display("FAIL queue c%0d: got %b want %b", i, {J, K, busy, cmd_ready, q_model, mismatch}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({busy, q_model, mismatch} !== 3'b010)
      $display("FAIL queue_final: got %b want 010", {busy, q_model, mismatch});
    else n_pass++;
  endtask

  task automatic test_toggle_unknown();
    cycle(0, HOLD, 0, 1);
    cycle(1, TOGGLE, 4, 0);
    fb_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fb_val = 1'($urandom);
      cycle(0, HOLD, 0, 0);
      n_total++;
      if ({dut.known, mismatch, J, K, busy} !== {2'b00, exp_vec()[5:3]})
        $display("FAIL toggle_unknown c%0d: got %b want %b", i, {dut.known, mismatch, J, K, busy}, {2'b00, exp_vec()[5:3]});
      else n_pass++;
    end
    fb_force = 1'b0;
    cycle(1, RESET, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, HOLD, 0, 0);
    n_total++;
    if ({dut.known, mismatch, q_model} !== 3'b100)
      $display("FAIL toggle_then_reset: got %b want 100", {dut.known, mismatch, q_model});
    else n_pass++;
  endtask

  task automatic test_mismatch();
    cycle(0, HOLD, 0, 1);
    cycle(1, SET, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, HOLD, 0, 0);
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL mm_before: got %b want 0", mismatch);
    else n_pass++;
    fb_force = 1'b1; fb_val = 1'b0;
    cycle(0, HOLD, 0, 0);
    fb_force = 1'b0;
    n_total++;
    if (mismatch !== 1'b1) $display("FAIL mm_rise: got %b want 1", mismatch);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(0, HOLD, 0, 0);
    n_total++;
    if ({mismatch, m_mm} !== 2'b11) $display("FAIL mm_sticky: got %b want 1 (model %b)", mismatch, m_mm);
    else n_pass++;
    cycle(0, HOLD, 0, 1);
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL mm_clear: got %b want 0", mismatch);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    cycle(0, HOLD, 0, 1);
    cycle(1, TOGGLE, 10, 0);
    cycle(1, SET, 2, 0);
    cycle(1, RESET, 2, 0);
    n_total++;
    if ({J, K, busy} !== 3'b111) $display("FAIL midrun_driving: got %b want 111", {J, K, busy});
    else n_pass++;
    cycle(0, HOLD, 0, 1);
    n_total++;
    if ({J, K, busy, cmd_ready, dut.empty} !== 5'b00001)
      $display("FAIL midrun_reset: got %b want 00001", {J, K, busy, cmd_ready, dut.empty});
    else n_pass++;
    cycle(0, HOLD, 0, 0);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL midrun_release_ready: got %b want 1", cmd_ready);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cycle(0, HOLD, 0, 0);
      n_total++;
      if ({J, K, busy} !== 3'b000) $display("FAIL midrun_flushed c%0d: got %b want 000", i, {J, K, busy});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int target, cyc;
    bit v;
    cycle(0, HOLD, 0, 1);
    target = n_acc + 3 * DEPTH;
    cyc = 0;
    while (n_acc < target && cyc < 600) begin
      v = ($urandom_range(0, 3) != 0);
      cycle(v, 2'($urandom), int'($urandom_range(0, 3)), 0);
      cyc++;
      n_total++;
      if ({J, K, busy, cmd_ready, q_model, mismatch} !== exp_vec())
        $display("FAIL random c%0d: got %b want %b", cyc, {J, K, busy, cmd_ready, q_model, mismatch}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (n_acc < target) $display("FAIL random_timeout: accepted %0d want %0d", n_acc, target);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cycle(0, HOLD, 0, 0);
      n_total++;
      if ({J, K, busy, cmd_ready, q_model, mismatch} !== exp_vec())
        $display("FAIL random_drain c%0d: got %b want %b", i, {J, K, busy, cmd_ready, q_model, mismatch}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({busy, cmd_ready, mismatch} !== 3'b010)
      $display("FAIL random_end: got %b want 010", {busy, cmd_ready, mismatch});
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    flop_q = 1'($urandom);
    @(negedge clk);
    test_reset();
    test_set();
    test_queue_four();
    test_toggle_unknown();
    test_mismatch();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
